mc10_bus_arbiter: RTL and testbench
===================================

# mc10_bus_arbiter

Single-port memory bus arbiter between the 6801 CPU core and the video fetch engine. Each cycle it grants the shared RAM bus to exactly one requester, and stalls the CPU through its `hold` input when video wins a cycle the CPU needed. A bounded-stall policy guarantees CPU forward progress. It sits between `cpu01` and the system RAM/decoder and also drives the CPU `data_in` path for RAM reads.

## Interface
Parameters:
- MAX_STALL, 4: maximum consecutive CPU-needed cycles video may take before the CPU is forced a slot (range 1..15).
- ADDR_W, 16: bus address width.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cpu_vma  in  1  CPU valid memory address this cycle
- cpu_rw  in  1  1 = read, 0 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_hold  out  1  stall to CPU `hold`; combinational
- cpu_rdata  out  8  RAM read data to CPU; combinational passthrough of mem_rdata
- vid_req  in  1  video fetch request, level; held until acked
- vid_addr  in  ADDR_W  video fetch address
- vid_ack  out  1  video granted this cycle; combinational
- vid_valid  out  1  registered; high one cycle after each vid_ack
- vid_data  out  8  registered fetch data, valid with vid_valid
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write strobe, committed at clk edge
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, asynchronous within the cycle
- stall_cnt  out  16  saturating count of cycles with cpu_hold=1

## Operation
- Owner states in `owner_t`:
  - CPU_OWN: default.
  - VID_OWN: video took the last cycle.
  - CPU_FORCED: stall limit reached; CPU must be served.
- Grant rule, evaluated every cycle:
  - vid_ack = vid_req & !rst & (state != CPU_FORCED).
  - cpu_hold = vid_ack & cpu_vma.
- Bus mux:
  - When vid_ack=1: mem_addr=vid_addr, mem_we=0.
  - Otherwise: mem_addr=cpu_addr, mem_we = cpu_vma & !cpu_rw.
  - mem_wdata = cpu_wdata always.
- stall counter `burst` (4 bit):
  - Increments when cpu_hold=1.
  - Clears on any cycle with cpu_hold=0.
  - When burst+1 == MAX_STALL on a held cycle, next state = CPU_FORCED.
- CPU_FORCED:
  - Video is refused for one cycle regardless of cpu_vma.
  - Next state = CPU_OWN and burst=0.
- Other transitions:
  - vid_ack -> VID_OWN.
  - No vid_ack -> CPU_OWN.
- A CPU cycle with cpu_vma=0 is never held. Video freely uses idle slots, and those slots do not count toward MAX_STALL.
- vid_valid/vid_data: on a vid_ack cycle, mem_rdata is registered. Otherwise vid_valid <= 0 and vid_data holds its value.
- stall_cnt increments on each cpu_hold=1 cycle and saturates at 16'hFFFF.

## Timing
- Reset values: state CPU_OWN, burst 0, vid_valid 0, vid_data 8'h00, stall_cnt 0.
- During rst: vid_ack=0, cpu_hold=0, mem_we=0.
- Read latency:
  - CPU: 0 cycles; RAM data is sampled by the CPU at the same edge.
  - Video: 1 cycle; data appears on vid_data/vid_valid in the cycle after vid_ack.
- Writes commit at the rising edge ending the cycle in which mem_we=1. A held CPU write is never committed; the CPU repeats it when released.
- Simultaneous request by CPU (vma=1) and video:
  - Video wins unless in CPU_FORCED.
  - Worst-case CPU stall is MAX_STALL cycles, followed by a guaranteed CPU cycle.
- vid_req dropping mid-sequence: the CPU owns the next cycle, and burst clears on the first unheld cycle.
- rst asserted mid-operation: the in-flight video grant is cancelled, no vid_valid follows, and counters clear.

## Structure
- Package `mc10_bus_pkg`: `owner_t` enum (CPU_OWN, VID_OWN, CPU_FORCED) and the default MAX_STALL constant.
- One natural sub-module, `sat_counter16`: the saturating stall_cnt counter. Everything else lives in the top module.
- The CPU `hold` input is driven by cpu_hold through an OR with any existing hold sources at the system top.

## Test plan
- **Reset:** assert rst with vid_req=1 and cpu_vma=1. Required: vid_ack=0, cpu_hold=0, mem_we=0; after release, all outputs are at their reset values.
- **CPU-only traffic:** CPU writes 8'hA5 to 16'h4000, then reads it back. Required: mem_we=1 for one cycle, cpu_rdata=8'hA5, cpu_hold never asserted.
- **Video in idle slot:** cpu_vma=0, vid_req=1, vid_addr=16'h4100 holding 8'h3C. Required: vid_ack=1, cpu_hold=0, next cycle vid_valid=1 with vid_data=8'h3C, burst stays 0.
- **Contention with MAX_STALL=4:** continuous vid_req and cpu_vma=1. Required: cpu_hold=1 for exactly 4 cycles, then 1 cycle with vid_ack=0 and cpu_hold=0; the pattern repeats with stall_cnt incrementing by 4 per period.
- **Held write:** CPU write to 16'h4200 while video wins. Required: no mem_we while held; the write commits in the first unheld cycle and RAM holds the CPU value.
- **Mid-burst reset:** rst asserted on a vid_ack cycle. Required: vid_valid=0 in the next cycle, and state and stall_cnt return to reset values.

Source files
------------

// File: rtl/mc10_bus_pkg.sv
// mc10_bus_pkg: bus ownership states and default stall bound for the MC-10 arbiter
package mc10_bus_pkg;
    typedef enum logic [1:0] {CPU_OWN, VID_OWN, CPU_FORCED} owner_t;
    localparam int MAX_STALL_DEF = 4;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q;
    // count qualifying cycles, holding at 16'hFFFF once reached
    always_ff @(posedge clk)
        cnt_q <= rst ? 16'h0000 : (inc_i && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/mc10_bus_arbiter.sv
// mc10_bus_arbiter: single-port RAM arbitration between 6801 CPU and video fetch with bounded CPU stall
module mc10_bus_arbiter
    import mc10_bus_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEF,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_vma,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_hold,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [7:0]        vid_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       stall_cnt
);
    owner_t     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       vid_valid_q;
    logic [7:0] vid_data_q;

    // grant, stall and bus steering for the current cycle
    always_comb begin
        vid_ack   = vid_req && !rst && state_q != CPU_FORCED;
        cpu_hold  = vid_ack && cpu_vma;
        mem_addr  = vid_ack ? vid_addr : cpu_addr;
        mem_we    = !rst && !vid_ack && cpu_vma && !cpu_rw;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
    end

    // next owner: only held cycles build toward the forced CPU slot
    always_comb begin
        burst_d = cpu_hold ? burst_q + 4'd1 : 4'd0;
        state_d = (cpu_hold && burst_q + 4'd1 == 4'(MAX_STALL)) ? CPU_FORCED :
                  vid_ack ? VID_OWN : CPU_OWN;
    end

    // owner and burst registers
    always_ff @(posedge clk) begin
        state_q <= rst ? CPU_OWN : state_d;
        burst_q <= rst ? 4'd0 : burst_d;
    end

    // capture video fetch data one cycle after its grant
    always_ff @(posedge clk) begin
        vid_valid_q <= !rst && vid_ack;
        vid_data_q  <= rst ? 8'h00 : vid_ack ? mem_rdata : vid_data_q;
    end

    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (cpu_hold),
        .cnt_o (stall_cnt)
    );
endmodule

// File: tb/tb_mc10_bus_arbiter.sv
// tb_mc10_bus_arbiter: directed checks of grant, stall bound, held writes and reset
module tb_mc10_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst, cpu_vma, cpu_rw, vid_req;
    logic [15:0] cpu_addr, vid_addr, mem_addr, stall_cnt;
    logic [7:0]  cpu_wdata, cpu_rdata, vid_data, mem_wdata, mem_rdata;
    logic        cpu_hold, vid_ack, vid_valid, mem_we;
    logic [7:0]  ram [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt;

    always #5 clk = ~clk;

    mc10_bus_arbiter dut (
        .clk(clk), .rst(rst), .cpu_vma(cpu_vma), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_valid(vid_valid),
        .vid_data(vid_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        ram[16'h4000] = 8'h00;
        ram[16'h4100] = 8'h3C;
        ram[16'h4200] = 8'h00;
        rst = 1; vid_req = 1; cpu_vma = 1; cpu_rw = 0;
        cpu_addr = 16'h4000; cpu_wdata = 8'hA5; vid_addr = 16'h4100;
        @(negedge clk); #1;
        chk("rst_ack", vid_ack, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_we", mem_we, 0);
        @(negedge clk);
        rst = 0; vid_req = 0; cpu_vma = 0; #1;
        chk("rst_valid", vid_valid, 0);
        chk("rst_vdata", vid_data, 8'h00);
        chk("rst_cnt", stall_cnt, 0);
        // CPU write then read back
        cpu_vma = 1; cpu_rw = 0; cpu_addr = 16'h4000; cpu_wdata = 8'hA5; #1;
        chk("cw_we", mem_we, 1);
        chk("cw_addr", mem_addr, 16'h4000);
        chk("cw_hold", cpu_hold, 0);
        @(negedge clk);
        cpu_rw = 1; #1;
        chk("cr_we", mem_we, 0);
        chk("cr_data", cpu_rdata, 8'hA5);
        chk("cr_hold", cpu_hold, 0);
        // video in an idle CPU slot
        @(negedge clk);
        cpu_vma = 0; vid_req = 1; vid_addr = 16'h4100; #1;
        chk("vi_ack", vid_ack, 1);
        chk("vi_hold", cpu_hold, 0);
        chk("vi_addr", mem_addr, 16'h4100);
        chk("vi_we", mem_we, 0);
        @(negedge clk);
        vid_req = 0; #1;
        chk("vi_valid", vid_valid, 1);
        chk("vi_data", vid_data, 8'h3C);
        chk("vi_cnt", stall_cnt, 0);
        @(negedge clk); #1;
        chk("vi_valid_drop", vid_valid, 0);
        chk("vi_data_hold", vid_data, 8'h3C);
        // sustained contention: 4 held cycles then one forced CPU slot
        exp_cnt = 0;
        vid_req = 1; cpu_vma = 1; cpu_rw = 1; cpu_addr = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("ct_hold%0d", i), cpu_hold, (i % 5) < 4);
            chk($sformatf("ct_ack%0d", i), vid_ack, (i % 5) < 4);
            chk($sformatf("ct_cnt%0d", i), stall_cnt, exp_cnt);
            if ((i % 5) < 4) exp_cnt++;
            @(negedge clk);
        end
        #1;
        chk("ct_cnt_end", stall_cnt, 8);
        // held write commits only once released
        cpu_rw = 0; cpu_addr = 16'h4200; cpu_wdata = 8'h5A; vid_addr = 16'h4100;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("hw_hold%0d", i), cpu_hold, 1);
            chk($sformatf("hw_we%0d", i), mem_we, 0);
            @(negedge clk);
        end
        chk("hw_ram_pre", ram[16'h4200], 8'h00);
        vid_req = 0; #1;
        chk("hw_hold_rel", cpu_hold, 0);
        chk("hw_we_rel", mem_we, 1);
        chk("hw_addr_rel", mem_addr, 16'h4200);
        @(negedge clk);
        cpu_rw = 1; #1;
        chk("hw_rdata", cpu_rdata, 8'h5A);
        chk("hw_ram", ram[16'h4200], 8'h5A);
        // burst cleared by the unheld cycle: a full 4-cycle stall again
        vid_req = 1; cpu_addr = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rb_hold%0d", i), cpu_hold, i < 4);
            @(negedge clk);
        end
        #1;
        chk("rb_cnt", stall_cnt, 14);
        // reset landing on a video grant cycle
        cpu_vma = 0; #1;
        chk("mr_ack_pre", vid_ack, 1);
        rst = 1; #1;
        chk("mr_ack_cancel", vid_ack, 0);
        @(negedge clk);
        rst = 0; vid_req = 0; #1;
        chk("mr_valid", vid_valid, 0);
        chk("mr_cnt", stall_cnt, 0);
        chk("mr_vdata", vid_data, 8'h00);
        vid_req = 1; cpu_vma = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mr_hold%0d", i), cpu_hold, i < 4);
            @(negedge clk);
        end
        #1;
        chk("mr_cnt_end", stall_cnt, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
